// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, byte type and command opcodes
// used by the SPI front end and the command state machine downstream.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

    localparam spi_byte_t CMD_WRITE_8BIT_REG = 8'h87;
    localparam spi_byte_t CMD_RX_DATA        = 8'h88;
    localparam spi_byte_t CMD_RX_SD_DATA     = 8'h89;

endpackage

// File: rtl/spi_slave_byte_if_if.sv
// SPI pins plus byte-stream handshake between the SPI front end (slave)
// and its environment: the SPI master and the command consumer (master).
interface spi_slave_byte_if_if;
    import spi_pkg::*;

    logic      sck;
    logic      cs_n;
    logic      mosi;
    logic      miso;
    spi_byte_t rx_data;
    logic      rx_valid;
    spi_byte_t tx_data;
    logic      tx_valid;
    logic      tx_pending;
    logic      frame_err;

    modport slave (
        input  sck, cs_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid, tx_pending, frame_err
    );

    modport master (
        output sck, cs_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid, tx_pending, frame_err
    );

endinterface

// File: rtl/spi_slave_byte_if_sync_ff.sv
// Generic multi-flop synchroniser for one asynchronous input bit.
// All stages reset to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave front end: oversamples SCK/CS_N/MOSI on clk, delivers
// received bytes as rx_data/rx_valid and shifts reply bytes out on MISO.
module spi_slave_byte_if
    import spi_pkg::*;
#(
    parameter int        SYNC_STAGES  = 2,
    parameter spi_byte_t IDLE_TX_BYTE = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    spi_slave_byte_if_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    logic      w_sck_s, w_cs_n_s, w_mosi_s;
    logic      r_sck_d, r_cs_n_d;
    logic      w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

    state_e    r_state, w_state_nxt;
    logic      r_armed;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;           // only the 7 most recent bits are ever needed
    spi_byte_t r_tx_shift, r_hold, r_rx_data;
    logic      r_tx_pending, r_rx_valid, r_frame_err, r_miso;

    logic      w_sample, w_load, w_shift, w_go_idle, w_abort, w_byte_done;
    spi_byte_t w_rx_next, w_load_src;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .rst(rst), .i_d(bus.sck),  .o_q(w_sck_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs_n (.clk(clk), .rst(rst), .i_d(bus.cs_n), .o_q(w_cs_n_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst(rst), .i_d(bus.mosi), .o_q(w_mosi_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_d  <= 1'b0;
            r_cs_n_d <= 1'b0;
        end else begin
            r_sck_d  <= w_sck_s;
            r_cs_n_d <= w_cs_n_s;
        end
    end

    assign w_sck_rise = w_sck_s  & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s &  r_sck_d;
    assign w_cs_rise  = w_cs_n_s & ~r_cs_n_d;
    assign w_cs_fall  = ~w_cs_n_s & r_cs_n_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_cs_fall && r_armed) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_rise)            w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode; cs_n rise wins over a coincident sck edge
    always_comb begin
        w_sample  = 1'b0;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_go_idle = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            ST_IDLE: w_load = w_cs_fall & r_armed;
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_go_idle = 1'b1;
                    w_abort   = (r_bit_cnt != 3'd0);
                end else if (!w_cs_n_s && r_armed) begin
                    w_sample = w_sck_rise;
                    w_load   = w_sck_fall & (r_bit_cnt == 3'd0);
                    w_shift  = w_sck_fall & (r_bit_cnt != 3'd0);
                end
            end
            default: ;
        endcase
    end

    assign w_byte_done = w_sample & (r_bit_cnt == 3'd7);
    assign w_rx_next   = {r_rx_shift, w_mosi_s};
    assign w_load_src  = r_tx_pending ? r_hold : IDLE_TX_BYTE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed      <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_tx_shift   <= '0;
            r_hold       <= '0;
            r_tx_pending <= 1'b0;
            r_miso       <= 1'b0;
        end else begin
            if (w_cs_n_s) r_armed <= 1'b1;
            r_rx_valid  <= w_byte_done;
            r_frame_err <= w_abort;

            if (w_sample) begin
                r_rx_shift <= w_rx_next[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) r_rx_data <= w_rx_next;

            if (w_go_idle) begin
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end

            if (w_load) begin
                r_tx_shift   <= w_load_src;
                r_miso       <= w_load_src[7];
                r_tx_pending <= 1'b0;
            end else if (w_shift) begin
                r_tx_shift <= r_tx_shift << 1;
                r_miso     <= r_tx_shift[6];
            end

            // A write coinciding with a load stays pending for the next byte
            if (bus.tx_valid) begin
                r_hold       <= bus.tx_data;
                r_tx_pending <= 1'b1;
            end
        end
    end

    assign bus.miso       = r_miso;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.tx_pending = r_tx_pending;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Self-checking bench for spi_slave_byte_if: SPI mode-0 master at 10 MHz
// against a 100 MHz clk, with a byte-level model of the reply path.
module tb_spi_slave_byte_if;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_slave_byte_if_if bus ();

    spi_slave_byte_if #(.SYNC_STAGES(2), .IDLE_TX_BYTE(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor/driver side: the only writer of rx_log, rx_cnt, fe_cnt, tx_valid/tx_data
    spi_byte_t rx_log[$];
    int        rx_cnt      = 0;
    int        fe_cnt      = 0;
    int        tx_done_cnt = 0;

    // Stimulus side requests
    int        tx_req_cnt  = 0;
    spi_byte_t tx_req_data = 8'h00;
    int        reply_at    = -1;
    spi_byte_t reply_byte  = 8'h00;

    // Reference model of the reply holding register
    bit        m_pending = 1'b0;
    spi_byte_t m_hold    = 8'h00;

    always @(negedge clk) begin
        bit fire;
        fire = 1'b0;
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.rx_valid === 1'b1) begin
            rx_log.push_back(bus.rx_data);
            rx_cnt++;
            if (rx_cnt == reply_at) fire = 1'b1;
        end
        if (tx_req_cnt != tx_done_cnt) begin
            bus.tx_data  = tx_req_data;
            bus.tx_valid = 1'b1;
            tx_done_cnt++;
        end else if (fire) begin
            bus.tx_data  = reply_byte;
            bus.tx_valid = 1'b1;
        end else begin
            bus.tx_valid = 1'b0;
        end
    end

    // Byte the slave must shift out next: pending reply, else the idle byte
    function automatic spi_byte_t model_load();
        spi_byte_t v;
        v = m_pending ? m_hold : 8'h00;
        m_pending = 1'b0;
        return v;
    endfunction

    task automatic host_write(input spi_byte_t v);
        tx_req_data = v;
        tx_req_cnt++;
        m_hold    = v;
        m_pending = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Shift nbits of b (MSB first); returns what the slave drove on miso
    task automatic send_bits(input spi_byte_t b, input int nbits, output spi_byte_t m);
        m = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = b[i];
            #50;
            m[i] = bus.miso;
            bus.sck = 1'b1;
            #50;
            bus.sck = 1'b0;
        end
    endtask

    // One complete frame; optional reply written right after byte reply_idx
    task automatic run_frame(input spi_byte_t data[$], input int reply_idx,
                             input spi_byte_t reply_val, input string tag);
        spi_byte_t exp_tx, got;
        int base, fe_base;
        @(negedge clk);
        base     = rx_cnt;
        fe_base  = fe_cnt;
        reply_at = (reply_idx >= 0) ? base + reply_idx + 1 : -1;
        reply_byte = reply_val;
        bus.cs_n = 1'b0;
        exp_tx   = model_load();
        for (int i = 0; i < data.size(); i++) begin
            send_bits(data[i], 8, got);
            n_cmp++;
            if (got !== exp_tx) begin
                n_err++;
                $display("FAIL %s miso byte %0d: got %02h expected %02h", tag, i, got, exp_tx);
            end
            if (i == reply_idx) begin
                m_hold    = reply_val;
                m_pending = 1'b1;
            end
            exp_tx = model_load();
        end
        #50;
        bus.cs_n = 1'b1;
        #100;
        reply_at = -1;
        n_cmp++;
        if (rx_cnt - base != data.size()) begin
            n_err++;
            $display("FAIL %s rx count: got %0d expected %0d", tag, rx_cnt - base, data.size());
        end else begin
            for (int i = 0; i < data.size(); i++) begin
                n_cmp++;
                if (rx_log[base + i] !== data[i]) begin
                    n_err++;
                    $display("FAIL %s rx byte %0d: got %02h expected %02h", tag, i, rx_log[base + i], data[i]);
                end
            end
        end
        n_cmp++;
        if (fe_cnt != fe_base) begin
            n_err++;
            $display("FAIL %s frame_err: got %0d pulses expected 0", tag, fe_cnt - fe_base);
        end
        n_cmp++;
        if (bus.tx_pending !== m_pending) begin
            n_err++;
            $display("FAIL %s tx_pending: got %b expected %b", tag, bus.tx_pending, m_pending);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if ({bus.miso, bus.rx_data, bus.rx_valid, bus.tx_pending, bus.frame_err} !== 12'h000) begin
            n_err++;
            $display("FAIL %s reset outputs: got miso=%b rx_data=%02h rx_valid=%b tx_pending=%b frame_err=%b expected all 0",
                     tag, bus.miso, bus.rx_data, bus.rx_valid, bus.tx_pending, bus.frame_err);
        end
    endtask

    task automatic test_reset();
        bus.sck  = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_basic();
        run_frame('{CMD_WRITE_8BIT_REG, 8'h5A}, -1, 8'h00, "basic");
    endtask

    task automatic test_reply();
        run_frame('{CMD_RX_SD_DATA, 8'h03, 8'h00}, 0, 8'hC3, "reply");
    endtask

    task automatic test_frame_err();
        spi_byte_t got;
        int base, fe_base;
        @(negedge clk);
        base    = rx_cnt;
        fe_base = fe_cnt;
        bus.cs_n = 1'b0;
        void'(model_load());
        send_bits(8'hFF, 5, got);
        #50;
        bus.cs_n = 1'b1;
        #100;
        n_cmp++;
        if (fe_cnt - fe_base != 1) begin
            n_err++;
            $display("FAIL frame_err pulses: got %0d expected 1", fe_cnt - fe_base);
        end
        n_cmp++;
        if (rx_cnt != base) begin
            n_err++;
            $display("FAIL frame_err rx count: got %0d expected 0", rx_cnt - base);
        end
        run_frame('{CMD_RX_DATA}, -1, 8'h00, "after_abort");
    endtask

    task automatic test_overwrite();
        host_write(8'h11);
        host_write(8'h22);
        n_cmp++;
        if (bus.tx_pending !== 1'b1) begin
            n_err++;
            $display("FAIL overwrite tx_pending: got %b expected 1", bus.tx_pending);
        end
        n_cmp++;
        if (m_hold !== 8'h22) begin
            n_err++;
            $display("FAIL overwrite model: got %02h expected 22", m_hold);
        end
        run_frame('{8'($urandom), 8'($urandom)}, -1, 8'h00, "overwrite");
    endtask

    task automatic test_reset_mid();
        spi_byte_t got;
        int base, fe_base;
        @(negedge clk);
        bus.cs_n = 1'b0;
        void'(model_load());
        send_bits(8'hA5, 3, got);
        rst = 1'b1;
        m_pending = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_mid_hold");
        rst = 1'b0;
        base    = rx_cnt;
        fe_base = fe_cnt;
        send_bits(8'hA5, 5, got);
        send_bits(8'h3C, 8, got);
        n_cmp++;
        if (got !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid miso: got %02h expected 00", got);
        end
        #50;
        bus.cs_n = 1'b1;
        #100;
        n_cmp++;
        if (rx_cnt != base || fe_cnt != fe_base) begin
            n_err++;
            $display("FAIL reset_mid ignored frame: got rx=%0d fe=%0d expected rx=0 fe=0",
                     rx_cnt - base, fe_cnt - fe_base);
        end
        run_frame('{CMD_RX_DATA, 8'($urandom)}, -1, 8'h00, "reset_mid_next");
    endtask

    task automatic test_stream();
        spi_byte_t data[$];
        spi_byte_t start;
        start = 8'($urandom);
        for (int i = 0; i < 256; i++) data.push_back(start + 8'(i));
        run_frame(data, int'($urandom_range(0, 254)), 8'($urandom), "stream");
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            spi_byte_t data[$];
            int len;
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) data.push_back(8'($urandom));
            if (($urandom & 1) != 0) host_write(8'($urandom));
            run_frame(data, int'($urandom_range(0, 4)) - 1, 8'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reply();
        test_frame_err();
        test_overwrite();
        test_reset_mid();
        test_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
